// File: rtl/t05_fin_tracker.sv
// Completion tracker feeding the t05 pipeline controller: validates stage done/error pulses
// against the fed-back controller state and emits finState/op_fin. Optional stall watchdog: T05_FIN_WATCHDOG_EN.
module t05_fin_tracker #(
  parameter int MAX_HT_LOOPS   = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cont_en,
  input  logic       restart_en,
  input  logic [3:0] state_reg,
  input  logic       fin_HG,
  input  logic       fin_FLV,
  input  logic       fin_HT,
  input  logic       fin_FINISHED,
  input  logic       fin_CBS,
  input  logic       fin_TRN,
  input  logic       fin_SPI,
  input  logic       error_FIN_HG,
  input  logic       error_FIN_FLV,
  input  logic       error_FIN_HT,
  input  logic       error_FIN_FINISHED,
  input  logic       error_FIN_CBS,
  input  logic       error_FIN_TRN,
  input  logic       error_FIN_SPI,
  output logic [8:0] finState,
  output logic [5:0] op_fin,
  output logic [2:0] err_src,
  output logic [8:0] ht_loops
);

  localparam logic [8:0] IDLE_FIN       = 9'h100;
  localparam logic [8:0] HFIN           = 9'h180;
  localparam logic [8:0] FLV_FIN        = 9'h1C0;
  localparam logic [8:0] HTREE_FIN      = 9'h1E0;
  localparam logic [8:0] HTREE_FINISHED = 9'h1D0;
  localparam logic [8:0] CBS_FIN        = 9'h1D8;
  localparam logic [8:0] TRN_FIN        = 9'h1DC;
  localparam logic [8:0] SPI_FIN        = 9'h1DE;
  localparam logic [8:0] ERROR_FIN      = 9'h1FF;

  localparam logic [2:0] E_NONE = 3'd0, E_STAGE = 3'd1, E_PROTO = 3'd2, E_LOOP = 3'd3, E_TMO = 3'd4;

  logic [8:0] r_fin_state;
  logic [5:0] r_op_fin;
  logic [2:0] r_err_src;
  logic [8:0] r_ht_loops;

  logic [6:0] w_fin_vec;
  logic       w_err_any;
  logic       w_ok;
  logic       w_dup;
  logic [8:0] w_code;
  logic [5:0] w_op;
  logic       w_legal;
  logic       w_proto;
  logic       w_loop_ovf;
  logic       w_wd_hit;

  assign w_fin_vec = {fin_SPI, fin_TRN, fin_CBS, fin_FINISHED, fin_HT, fin_FLV, fin_HG};
  assign w_err_any = error_FIN_HG | error_FIN_FLV | error_FIN_HT | error_FIN_FINISHED |
                     error_FIN_CBS | error_FIN_TRN | error_FIN_SPI;

  // Only one-hot fin vectors decode; simultaneous pulses fall to default and become protocol errors.
  always_comb begin
    w_ok   = 1'b0;
    w_dup  = 1'b0;
    w_code = r_fin_state;
    w_op   = r_op_fin;
    case (w_fin_vec)
      7'b0000001: begin
        w_code = HFIN;  w_op = 6'd1;
        w_ok   = (r_fin_state == IDLE_FIN) && (state_reg == 4'd1);
        w_dup  = (r_fin_state == HFIN);
      end
      7'b0000010: begin
        w_code = FLV_FIN;  w_op = 6'd2;
        w_ok   = ((r_fin_state == HFIN) || (r_fin_state == HTREE_FIN)) && (state_reg == 4'd2);
        w_dup  = (r_fin_state == FLV_FIN);
      end
      7'b0000100: begin
        w_code = HTREE_FIN;  w_op = 6'd3;
        w_ok   = (r_fin_state == FLV_FIN) && (state_reg == 4'd3);
        w_dup  = (r_fin_state == HTREE_FIN);
      end
      7'b0001000: begin
        w_code = HTREE_FINISHED;  w_op = 6'd3;
        w_ok   = (r_fin_state == FLV_FIN) && (state_reg == 4'd3);
        w_dup  = (r_fin_state == HTREE_FINISHED);
      end
      7'b0010000: begin
        w_code = CBS_FIN;  w_op = 6'd4;
        w_ok   = (r_fin_state == HTREE_FINISHED) && (state_reg == 4'd4);
        w_dup  = (r_fin_state == CBS_FIN);
      end
      7'b0100000: begin
        w_code = TRN_FIN;  w_op = 6'd5;
        w_ok   = (r_fin_state == CBS_FIN) && (state_reg == 4'd5);
        w_dup  = (r_fin_state == TRN_FIN);
      end
      7'b1000000: begin
        w_code = SPI_FIN;  w_op = 6'd6;
        w_ok   = (r_fin_state == TRN_FIN) && (state_reg == 4'd6);
        w_dup  = (r_fin_state == SPI_FIN);
      end
      default: ;
    endcase
  end

  assign w_legal    = w_ok;
  assign w_proto    = (|w_fin_vec) && !w_ok && !w_dup;
  assign w_loop_ovf = w_legal && fin_HT && (r_ht_loops == 9'(MAX_HT_LOOPS));

`ifdef T05_FIN_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic [3:0]  r_prev_state;
  logic        w_wd_active;
  logic        w_wd_clr;

  assign w_wd_active = (state_reg >= 4'd1) && (state_reg <= 4'd6) &&
                       (r_fin_state != 9'h000) && (r_fin_state != ERROR_FIN);
  assign w_wd_clr    = w_legal || (state_reg != r_prev_state);
  // Fires on the edge at which the counter would reach the limit.
  assign w_wd_hit    = w_wd_active && !w_wd_clr && (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt     <= '0;
      r_prev_state <= '0;
    end else begin
      r_prev_state <= state_reg;
      if (restart_en || w_wd_clr) r_wd_cnt <= '0;
      else if (w_wd_active)       r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end
`else
  // No watchdog in this build: the timeout can never fire.
  assign w_wd_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fin_state <= '0;
      r_op_fin    <= '0;
      r_err_src   <= E_NONE;
      r_ht_loops  <= '0;
    end else if (restart_en) begin
      r_fin_state <= '0;
      r_op_fin    <= '0;
      r_err_src   <= E_NONE;
      r_ht_loops  <= '0;
    end else if (r_fin_state == ERROR_FIN) begin
      // sticky until restart; first cause is kept
    end else if (w_err_any && (r_fin_state != 9'h000)) begin
      r_fin_state <= ERROR_FIN;  r_op_fin <= 6'd7;  r_err_src <= E_STAGE;
    end else if (w_proto) begin
      r_fin_state <= ERROR_FIN;  r_op_fin <= 6'd7;  r_err_src <= E_PROTO;
    end else if (w_loop_ovf) begin
      r_fin_state <= ERROR_FIN;  r_op_fin <= 6'd7;  r_err_src <= E_LOOP;
    end else if (w_wd_hit) begin
      r_fin_state <= ERROR_FIN;  r_op_fin <= 6'd7;  r_err_src <= E_TMO;
    end else if (w_legal) begin
      r_fin_state <= w_code;
      r_op_fin    <= w_op;
      if (fin_HT) r_ht_loops <= r_ht_loops + 9'd1;
    end else if (cont_en && (r_fin_state == 9'h000)) begin
      r_fin_state <= IDLE_FIN;
      r_op_fin    <= 6'd0;
    end
  end

  assign finState = r_fin_state;
  assign op_fin   = r_op_fin;
  assign err_src  = r_err_src;
  assign ht_loops = r_ht_loops;

endmodule

// File: tb/tb_t05_fin_tracker.sv
// Directed bench for t05_fin_tracker (MAX_HT_LOOPS=2, TIMEOUT_CYCLES=10); the watchdog
// check follows T05_FIN_WATCHDOG_EN.
module tb_t05_fin_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cont_en = 1'b0;
  logic       restart_en = 1'b0;
  logic [3:0] state_reg = 4'd0;
  logic [6:0] fin_v = '0;   // {SPI,TRN,CBS,FINISHED,HT,FLV,HG}
  logic [6:0] err_v = '0;
  logic [8:0] finState;
  logic [5:0] op_fin;
  logic [2:0] err_src;
  logic [8:0] ht_loops;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] F_HG = 7'b0000001, F_FLV = 7'b0000010, F_HT = 7'b0000100,
                         F_FN = 7'b0001000, F_CBS = 7'b0010000, F_TRN = 7'b0100000,
                         F_SPI = 7'b1000000;

  always #5 clk = ~clk;

  t05_fin_tracker #(.MAX_HT_LOOPS(2), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .cont_en(cont_en), .restart_en(restart_en), .state_reg(state_reg),
    .fin_HG(fin_v[0]), .fin_FLV(fin_v[1]), .fin_HT(fin_v[2]), .fin_FINISHED(fin_v[3]),
    .fin_CBS(fin_v[4]), .fin_TRN(fin_v[5]), .fin_SPI(fin_v[6]),
    .error_FIN_HG(err_v[0]), .error_FIN_FLV(err_v[1]), .error_FIN_HT(err_v[2]),
    .error_FIN_FINISHED(err_v[3]), .error_FIN_CBS(err_v[4]), .error_FIN_TRN(err_v[5]),
    .error_FIN_SPI(err_v[6]),
    .finState(finState), .op_fin(op_fin), .err_src(err_src), .ht_loops(ht_loops)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [6:0] f, input logic [6:0] e = '0);
    fin_v = f;
    err_v = e;
    step();
    fin_v = '0;
    err_v = '0;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_restart();
    restart_en = 1'b1;
    step();
    restart_en = 1'b0;
    state_reg  = 4'd0;
  endtask

  // Accept a stage fin, then let the controller lag two cycles before moving on.
  task automatic stage(input logic [6:0] f, input logic [8:0] exp_fs, input logic [3:0] nxt,
                       input string tag);
    pulse(f);
    chk(tag, finState, exp_fs);
    step(2);
    state_reg = nxt;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step();
    chk("rst_finState", finState, 9'h000);
    chk("rst_op_fin",   9'(op_fin), 9'd0);
    chk("rst_err_src",  9'(err_src), 9'd0);
    chk("rst_ht_loops", ht_loops, 9'd0);

    // start, second cont_en ignored
    cont_en = 1'b1; step(); cont_en = 1'b0;
    chk("start_fs", finState, 9'h100);
    chk("start_op", 9'(op_fin), 9'd0);
    cont_en = 1'b1; step(); cont_en = 1'b0;
    chk("start2_fs", finState, 9'h100);

    // full run with one HT loop
    state_reg = 4'd1;
    pulse(F_HG);
    chk("hg_fs", finState, 9'h180);
    chk("hg_op", 9'(op_fin), 9'd1);
    pulse(F_HG);
    chk("hg_dup_fs", finState, 9'h180);
    step();
    state_reg = 4'd2;
    stage(F_FLV, 9'h1C0, 4'd3, "flv1_fs");
    stage(F_HT,  9'h1E0, 4'd2, "ht1_fs");
    chk("ht1_loops", ht_loops, 9'd1);
    chk("ht1_op", 9'(op_fin), 9'd3);
    stage(F_FLV, 9'h1C0, 4'd3, "flv2_fs");
    stage(F_FN,  9'h1D0, 4'd4, "fin_fs");
    stage(F_CBS, 9'h1D8, 4'd5, "cbs_fs");
    stage(F_TRN, 9'h1DC, 4'd6, "trn_fs");
    pulse(F_SPI);
    chk("spi_fs", finState, 9'h1DE);
    chk("spi_op", 9'(op_fin), 9'd6);
    step(3);
    state_reg = 4'd8;
    step(3);
    chk("spi_hold_fs", finState, 9'h1DE);
    chk("spi_hold_err", 9'(err_src), 9'd0);
    do_restart();
    chk("rs1_fs", finState, 9'h000);
    chk("rs1_loops", ht_loops, 9'd0);

    // protocol error, then sticky first cause
    cont_en = 1'b1; step(); cont_en = 1'b0;
    state_reg = 4'd1;
    pulse(F_HG);
    chk("p_hg_fs", finState, 9'h180);
    pulse(F_CBS);
    chk("proto_fs", finState, 9'h1FF);
    chk("proto_op", 9'(op_fin), 9'd7);
    chk("proto_err", 9'(err_src), 9'd2);
    pulse('0, 7'b0000001);
    chk("proto_sticky_err", 9'(err_src), 9'd2);
    do_restart();
    chk("rs2_fs", finState, 9'h000);

    // stage error beats simultaneous legal fin
    cont_en = 1'b1; step(); cont_en = 1'b0;
    state_reg = 4'd1;
    stage(F_HG,  9'h180, 4'd2, "s_hg_fs");
    stage(F_FLV, 9'h1C0, 4'd3, "s_flv_fs");
    stage(F_FN,  9'h1D0, 4'd4, "s_fin_fs");
    stage(F_CBS, 9'h1D8, 4'd5, "s_cbs_fs");
    pulse(F_TRN, F_TRN);
    chk("serr_fs", finState, 9'h1FF);
    chk("serr_err", 9'(err_src), 9'd1);
    state_reg = 4'd6;
    pulse(F_SPI);
    chk("serr_spi_fs", finState, 9'h1FF);
    chk("serr_spi_err", 9'(err_src), 9'd1);
    do_restart();
    chk("rs3_fs", finState, 9'h000);
    chk("rs3_op", 9'(op_fin), 9'd0);
    chk("rs3_err", 9'(err_src), 9'd0);

    // loop overflow with MAX_HT_LOOPS=2
    cont_en = 1'b1; step(); cont_en = 1'b0;
    state_reg = 4'd1;
    stage(F_HG,  9'h180, 4'd2, "l_hg_fs");
    stage(F_FLV, 9'h1C0, 4'd3, "l_flv1_fs");
    stage(F_HT,  9'h1E0, 4'd2, "l_ht1_fs");
    stage(F_FLV, 9'h1C0, 4'd3, "l_flv2_fs");
    stage(F_HT,  9'h1E0, 4'd2, "l_ht2_fs");
    chk("l_ht2_loops", ht_loops, 9'd2);
    stage(F_FLV, 9'h1C0, 4'd3, "l_flv3_fs");
    pulse(F_HT);
    chk("ovf_fs", finState, 9'h1FF);
    chk("ovf_err", 9'(err_src), 9'd3);
    chk("ovf_loops", ht_loops, 9'd2);
    do_restart();

    // stall in FLV
    cont_en = 1'b1; step(); cont_en = 1'b0;
    state_reg = 4'd1;
    pulse(F_HG);
    state_reg = 4'd2;
    step();       // state change seen here: counter starts from 0
    step(9);
    chk("wd_pre_fs", finState, 9'h180);
    step();
`ifdef T05_FIN_WATCHDOG_EN
    chk("wd_fs", finState, 9'h1FF);
    chk("wd_err", 9'(err_src), 9'd4);
`else
    chk("wd_fs", finState, 9'h180);
    chk("wd_err", 9'(err_src), 9'd0);
    step(20);
    chk("wd_long_fs", finState, 9'h180);
`endif
    do_restart();
    chk("rs_end_fs", finState, 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/t05_fin_tracker.md
Name: t05_fin_tracker

Overview:
- Sits directly upstream of the t05 pipeline controller and drives its 9-bit finState input and 6-bit op_fin input.
- Collects one-cycle done and error pulses from the HISTO, FLV, HTREE, CBS, TRN and SPI stages, and checks each pulse against the controller's fed-back state_reg.
- Encodes the latest accepted completion as the controller's finState code and holds it until the next legal completion, a restart, or an error.
- Also detects protocol violations, runaway FLV/HTREE looping and, optionally, stalled stages.

Parameters:
- MAX_HT_LOOPS, 256: maximum accepted fin_HT pulses per run; pulse number MAX_HT_LOOPS+1 is an error.
- TIMEOUT_CYCLES, 65535: watchdog limit in cycles per active stage (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cont_en  in  1  start request; honoured only while finState==0
- restart_en  in  1  synchronous clear back to finState==0
- state_reg  in  4  controller state (IDLE0 HISTO1 FLV2 HTREE3 CBS4 TRN5 SPI6 ERROR7 DONE8)
- fin_HG, fin_FLV, fin_HT, fin_FINISHED, fin_CBS, fin_TRN, fin_SPI  in  1 each  stage done pulses
- error_FIN_HG, error_FIN_FLV, error_FIN_HT, error_FIN_FINISHED, error_FIN_CBS, error_FIN_TRN, error_FIN_SPI  in  1 each  stage error pulses
- finState  out  9  registered completion code to the controller
- op_fin  out  6  registered stage code of the last accepted event (IDLE_S0 HIST_S1 FLV_S2 HTREE_S3 CBS_S4 TRN_S5 SPI_S6 ERROR_S7)
- err_src  out  3  cause of the error: 0 none, 1 stage error, 2 protocol, 3 loop overflow, 4 timeout
- ht_loops  out  9  count of accepted fin_HT pulses

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: finState=0, op_fin=0, err_src=0, ht_loops=0, watchdog counter=0. Reset mid-run aborts immediately.
- Completion codes:
  - IDLE_FIN 0x100, HFIN 0x180, FLV_FIN 0x1C0, HTREE_FIN 0x1E0, HTREE_FINISHED 0x1D0
  - CBS_FIN 0x1D8, TRN_FIN 0x1DC, SPI_FIN 0x1DE, ERROR_FIN 0x1FF
- Latency: every output updates on the clock edge after the causing input. All outputs are registered; there is no combinational path from inputs to outputs.
- Priority, highest first: restart_en > any error_FIN_* > protocol/loop/timeout checks > legal fin > cont_en.
- restart_en: finState=0, op_fin=0, err_src=0, ht_loops=0, watchdog counter cleared. It also clears a held ERROR_FIN.
- Start: cont_en while finState==0 loads finState=IDLE_FIN and op_fin=IDLE_S. Ignored in any other finState.
- Legal acceptance requires both the predecessor finState and the matching state_reg:
  - fin_HG: finState=IDLE_FIN, state_reg=1 -> HFIN, op_fin=1
  - fin_FLV: finState in {HFIN, HTREE_FIN}, state_reg=2 -> FLV_FIN, op_fin=2
  - fin_HT: finState=FLV_FIN, state_reg=3 -> HTREE_FIN, op_fin=3, ht_loops+1
  - fin_FINISHED: finState=FLV_FIN, state_reg=3 -> HTREE_FINISHED, op_fin=3
  - fin_CBS: finState=HTREE_FINISHED, state_reg=4 -> CBS_FIN, op_fin=4
  - fin_TRN: finState=CBS_FIN, state_reg=5 -> TRN_FIN, op_fin=5
  - fin_SPI: finState=TRN_FIN, state_reg=6 -> SPI_FIN, op_fin=6
- Duplicate pulse: a fin whose own code already equals finState is silently ignored. This covers the two-cycle controller lag.
- Any other fin pulse, or two or more fin pulses in the same cycle, is a protocol error: finState=ERROR_FIN, op_fin=7, err_src=2.
- Any error_FIN_* pulse, when finState is neither 0 nor ERROR_FIN: ERROR_FIN, op_fin=7, err_src=1.
- Loop overflow: an accepted fin_HT with ht_loops==MAX_HT_LOOPS gives ERROR_FIN, err_src=3. ht_loops saturates and does not wrap.
- ERROR_FIN is sticky. All fin, error and cont_en inputs are ignored until restart_en or rst; err_src keeps the first cause.
- Hold: with no event, every output holds its value. SPI_FIN holds until restart_en.

Optional Feature:
- Macro: T05_FIN_WATCHDOG_EN.
- With the macro defined:
  - A 16-bit counter increments each cycle while state_reg is in 1..6 and finState is neither 0 nor ERROR_FIN.
  - The counter clears on any accepted fin and on any change of state_reg.
  - When the counter reaches TIMEOUT_CYCLES: ERROR_FIN, op_fin=7, err_src=4.
- Without the macro: no counter logic exists and err_src never takes the value 4.

Test Plan:
- Reset, then pulse cont_en -> finState=0x100 and op_fin=0 on the next edge. A second cont_en changes nothing.
- Model the controller with 2-cycle state_reg lag and drive HG, FLV, HT, FLV, FINISHED, CBS, TRN, SPI -> finState steps 0x180, 0x1C0, 0x1E0, 0x1C0, 0x1D0, 0x1D8, 0x1DC, 0x1DE; ht_loops=1; SPI_FIN holds until restart_en, then finState=0.
- fin_HG repeated one cycle after it was accepted (state_reg still 1) -> ignored, finState stays 0x180. fin_CBS while finState=0x180 -> 0x1FF, err_src=2.
- error_FIN_TRN and fin_TRN in the same cycle during TRN -> 0x1FF, err_src=1. A later fin_SPI is ignored. restart_en then clears all outputs to 0.
- MAX_HT_LOOPS=2, three FLV/HT loops -> the third fin_HT gives 0x1FF, err_src=3, ht_loops=2.
- With T05_FIN_WATCHDOG_EN and TIMEOUT_CYCLES=10: hold state_reg=2 with no fin -> 0x1FF, err_src=4 exactly 10 cycles after entry. Without the macro, finState stays 0x180.
